// File: rtl/axis_traffic_chk.sv
// axis_traffic_chk: AXI-Stream sink that checks an incrementing sequence with optional LFSR backpressure
module axis_traffic_chk #(
  parameter int                      DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0]   START_VAL  = DATA_WIDTH'(1),
  parameter int unsigned             NUM_BEATS  = 1024,
  parameter int                      READY_MODE = 0,
  parameter logic [15:0]             LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chk_en,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] axis_tdata,
  input  logic                  axis_tvalid,
  output logic                  axis_tready,
  output logic [31:0]           rx_count,
  output logic [15:0]           err_count,
  output logic                  err_flag,
  output logic [DATA_WIDTH-1:0] first_err_exp,
  output logic [DATA_WIDTH-1:0] first_err_act,
  output logic                  done,
  output logic                  pass
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic tready_nx;
  logic accept;
  logic last;
  logic [15:0] lfsr;
  logic [DATA_WIDTH-1:0] expected;
  assign accept = axis_tvalid && axis_tready;
  assign last = (NUM_BEATS != 0) && accept && (rx_count == NUM_BEATS - 1);
  assign done = state == DONE;
  assign pass = done && err_count == '0;
  // State register and registered ready; reset drops ready immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      axis_tready <= 1'b0;
    end else begin
      state <= state_nx;
      axis_tready <= tready_nx;
    end
  end
  // Next state and next-cycle ready; the final beat closes ready so nothing past NUM_BEATS is taken
  always_comb begin
    state_nx = state;
    tready_nx = 1'b0;
    if (clr) state_nx = IDLE;
    else case (state)
      IDLE: state_nx = chk_en ? RUN : IDLE;
      RUN: begin
        state_nx = last ? DONE : RUN;
        tready_nx = !last && (READY_MODE == 0 || lfsr[1:0] != 2'b00);
      end
      default: state_nx = DONE;
    endcase
  end
  // Checker datapath: resync expected to each received beat so one slip costs one error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= LFSR_SEED;
      expected <= START_VAL;
      rx_count <= '0;
      err_count <= '0;
      err_flag <= 1'b0;
      first_err_exp <= '0;
      first_err_act <= '0;
    end else if (clr) begin
      lfsr <= LFSR_SEED;
      expected <= START_VAL;
      rx_count <= '0;
      err_count <= '0;
      err_flag <= 1'b0;
      first_err_exp <= '0;
      first_err_act <= '0;
    end else begin
      if (state == RUN) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (accept) begin
        expected <= axis_tdata + DATA_WIDTH'(1);
        if (rx_count != '1) rx_count <= rx_count + 32'd1;
        if (axis_tdata != expected) begin
          if (err_count != '1) err_count <= err_count + 16'd1;
          if (!err_flag) begin
            err_flag <= 1'b1;
            first_err_exp <= expected;
            first_err_act <= axis_tdata;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_axis_traffic_chk.sv
// tb_axis_traffic_chk: table vectors on a 64-bit checker plus a model-checked random run on an 8-bit LFSR-throttled checker
module tb_axis_traffic_chk;
  logic clk = 1'b0;
  logic rst;
  logic en0, clr0, v0, rdy0, flag0, done0, pass0;
  logic [63:0] d0, fe0, fa0;
  logic [31:0] rx0;
  logic [15:0] err0;
  logic en1, clr1, v1, rdy1, flag1, done1, pass1;
  logic [7:0] d1, fe1, fa1;
  logic [31:0] rx1;
  logic [15:0] err1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  axis_traffic_chk #(.DATA_WIDTH(64), .START_VAL(64'd1), .NUM_BEATS(16), .READY_MODE(0)) u0 (
    .clk(clk), .rst(rst), .chk_en(en0), .clr(clr0), .axis_tdata(d0), .axis_tvalid(v0),
    .axis_tready(rdy0), .rx_count(rx0), .err_count(err0), .err_flag(flag0),
    .first_err_exp(fe0), .first_err_act(fa0), .done(done0), .pass(pass0));
  axis_traffic_chk #(.DATA_WIDTH(8), .START_VAL(8'hFE), .NUM_BEATS(200), .READY_MODE(1), .LFSR_SEED(16'hACE1)) u1 (
    .clk(clk), .rst(rst), .chk_en(en1), .clr(clr1), .axis_tdata(d1), .axis_tvalid(v1),
    .axis_tready(rdy1), .rx_count(rx1), .err_count(err1), .err_flag(flag1),
    .first_err_exp(fe1), .first_err_act(fa1), .done(done1), .pass(pass1));
  typedef struct {
    logic en, clr, v;
    logic [63:0] d;
    logic rdy;
    logic [31:0] rx;
    logic [15:0] err;
    logic dn;
    logic [63:0] fe, fa;
  } vec_t;
  vec_t tbl[$];
  // reference model state for u1
  int m_state;
  logic m_rdy, m_flag;
  logic [15:0] m_lfsr, m_err;
  logic [7:0] m_exp, m_fexp, m_fact;
  logic [31:0] m_rx;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic row(input logic en, input logic clr, input logic v, input logic [63:0] d, input logic rdy,
                     input logic [31:0] rx, input logic [15:0] err, input logic dn, input logic [63:0] fe, input logic [63:0] fa);
    vec_t r;
    r.en = en; r.clr = clr; r.v = v; r.d = d; r.rdy = rdy; r.rx = rx; r.err = err; r.dn = dn; r.fe = fe; r.fa = fa;
    tbl.push_back(r);
  endtask
  task automatic m_reset();
    m_state = 0; m_rdy = 1'b0; m_lfsr = 16'hACE1; m_exp = 8'hFE;
    m_rx = 0; m_err = 0; m_flag = 1'b0; m_fexp = 0; m_fact = 0;
  endtask
  task automatic m_step(input logic en, input logic clr, input logic v, input logic [7:0] d, output logic acc);
    acc = v && m_rdy;
    if (clr) m_reset();
    else if (m_state == 0) begin
      if (en) m_state = 1;
    end else if (m_state == 1) begin
      m_rdy = m_lfsr[1:0] != 2'b00;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      if (acc) begin
        if (d != m_exp) begin
          if (m_err != 16'hFFFF) m_err = m_err + 1;
          if (!m_flag) begin m_flag = 1'b1; m_fexp = m_exp; m_fact = d; end
        end
        m_exp = d + 8'd1;
        m_rx = m_rx + 1;
        if (m_rx == 200) begin m_state = 2; m_rdy = 1'b0; end
      end
    end
  endtask
  task automatic cmp1(input int cyc);
    string s;
    s = $sformatf("u1 c%0d", cyc);
    chk({s, " tready"}, rdy1, m_rdy);
    chk({s, " rx"}, rx1, m_rx);
    chk({s, " err"}, err1, m_err);
    chk({s, " flag"}, flag1, m_flag);
    chk({s, " done"}, done1, m_state == 2);
    chk({s, " pass"}, pass1, m_state == 2 && m_err == 0);
    chk({s, " fexp"}, fe1, m_fexp);
    chk({s, " fact"}, fa1, m_fact);
  endtask
  initial begin
    logic acc;
    logic [7:0] g;
    int lim, cyc;
    rst = 1'b0; en0 = 0; clr0 = 0; v0 = 0; d0 = 0; en1 = 0; clr1 = 0; v1 = 0; d1 = 0;
    m_reset();
    tick();
    tick();
    chk("rst tready0", rdy0, 0); chk("rst rx0", rx0, 0); chk("rst err0", err0, 0);
    chk("rst flag0", flag0, 0); chk("rst done0", done0, 0); chk("rst pass0", pass0, 0);
    chk("rst fexp0", fe0, 0); chk("rst fact0", fa0, 0); chk("rst tready1", rdy1, 0);
    rst = 1'b1;
    tick();
    // random run twice on u1, separated by clr; tready pattern must restart from the seed
    cyc = 0;
    for (int run = 0; run < 2; run++) begin
      g = 8'hFE; v1 = 1'b0; d1 = g; en1 = 1'b1; clr1 = 1'b0; lim = 0;
      do begin
        m_step(en1, clr1, v1, d1, acc);
        tick();
        cmp1(cyc++);
        en1 = 1'b0;
        if (acc) begin
          int r;
          r = $urandom_range(0, 15);
          g = (r == 0) ? g + 8'd2 : (r == 1) ? g : g + 8'd1;
          v1 = $urandom_range(0, 3) != 0;
        end else if (!v1) v1 = $urandom_range(0, 3) != 0;
        d1 = g;
        lim++;
      end while (m_state != 2 && lim < 3000);
      chk("u1 reached done", done1, 1);
      v1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
        m_step(en1, clr1, v1, d1, acc);
        tick();
        cmp1(cyc++);
      end
      clr1 = 1'b1;
      m_step(en1, clr1, v1, d1, acc);
      tick();
      cmp1(cyc++);
      clr1 = 1'b0; v1 = 1'b0;
    end
    // stream 1,2,3,5,6,7..17 with one bubble: one error, resync, done at 16
    row(1,0,0,0, 0,0,0,0, 0,0);
    row(0,0,1,1, 1,0,0,0, 0,0);
    for (int k = 0; k < 16; k++) begin
      if (k == 5) row(0,0,0,99, 1,5,1,0, 4,5);
      row(0,0,1, (k < 3) ? k + 1 : k + 2, k < 15, k + 1, (k >= 3) ? 16'd1 : 16'd0, k == 15,
          (k >= 3) ? 64'd4 : 64'd0, (k >= 3) ? 64'd5 : 64'd0);
    end
    row(0,0,1,18, 0,16,1,1, 4,5);
    row(0,1,0,0, 0,0,0,0, 0,0);
    // clean 16-beat run ends in pass; chk_en in DONE is ignored
    row(1,0,0,0, 0,0,0,0, 0,0);
    row(0,0,0,0, 1,0,0,0, 0,0);
    for (int k = 0; k < 16; k++) row(0,0,1,k + 1, k < 15, k + 1, 0, k == 15, 0,0);
    row(0,0,1,17, 0,16,0,1, 0,0);
    row(1,0,1,17, 0,16,0,1, 0,0);
    row(0,1,0,0, 0,0,0,0, 0,0);
    // clr beats a simultaneous accept, then expected restarts at START_VAL
    row(1,0,0,0, 0,0,0,0, 0,0);
    row(0,0,1,1, 1,0,0,0, 0,0);
    row(0,0,1,1, 1,1,0,0, 0,0);
    row(0,0,1,2, 1,2,0,0, 0,0);
    row(0,1,1,3, 0,0,0,0, 0,0);
    row(0,0,1,3, 0,0,0,0, 0,0);
    row(1,0,1,3, 0,0,0,0, 0,0);
    row(0,0,1,1, 1,0,0,0, 0,0);
    row(0,0,1,1, 1,1,0,0, 0,0);
    row(0,0,1,2, 1,2,0,0, 0,0);
    foreach (tbl[i]) begin
      string s;
      en0 = tbl[i].en; clr0 = tbl[i].clr; v0 = tbl[i].v; d0 = tbl[i].d;
      tick();
      s = $sformatf("u0 row%0d", i);
      chk({s, " tready"}, rdy0, tbl[i].rdy);
      chk({s, " rx"}, rx0, tbl[i].rx);
      chk({s, " err"}, err0, tbl[i].err);
      chk({s, " flag"}, flag0, tbl[i].err != 0);
      chk({s, " done"}, done0, tbl[i].dn);
      chk({s, " pass"}, pass0, tbl[i].dn && tbl[i].err == 0);
      chk({s, " fexp"}, fe0, tbl[i].fe);
      chk({s, " fact"}, fa0, tbl[i].fa);
    end
    en0 = 0; clr0 = 0;
    // continue to 10 beats, then pulse reset between edges
    for (int k = 3; k <= 10; k++) begin
      v0 = 1'b1; d0 = k;
      tick();
    end
    chk("pre-reset rx", rx0, 10);
    rst = 1'b0;
    #2;
    chk("async tready", rdy0, 0);
    chk("async rx", rx0, 0);
    chk("async err", err0, 0);
    chk("async done", done0, 0);
    tick();
    rst = 1'b1;
    en0 = 1'b1; v0 = 1'b1; d0 = 1;
    tick();
    chk("post-reset idle->run tready", rdy0, 0);
    en0 = 1'b0;
    tick();
    chk("post-reset tready up", rdy0, 1);
    chk("post-reset rx before beat", rx0, 0);
    tick();
    chk("post-reset rx", rx0, 1);
    chk("post-reset err", err0, 0);
    chk("post-reset flag", flag0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_traffic_chk.md
Name: axis_traffic_chk

Overview:
- AXI-Stream sink and checker that sits directly downstream of the incrementing traffic generator in NoC simulation benches.
- Accepts beats, applies fixed or pseudo-random backpressure, and checks each beat against a +1 incrementing sequence.
- Reports beat count, error count, first-error capture and a pass/done verdict to the testbench or status logic.

Parameters:
- DATA_WIDTH, 64, stream data width; must match the generator.
- START_VAL, 1, expected value of the first beat after reset or clear.
- NUM_BEATS, 1024, beats to accept before done; 0 = run forever.
- READY_MODE, 0, 0 = tready always high in RUN; 1 = LFSR-driven backpressure.
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- chk_en  in  1  start checking; sampled in IDLE.
- clr  in  1  synchronous clear; returns to IDLE and zeroes status.
- axis_tdata  in  DATA_WIDTH  stream data.
- axis_tvalid  in  1  stream valid.
- axis_tready  out  1  stream ready, registered.
- rx_count  out  32  accepted beats, saturates at 32'hFFFFFFFF.
- err_count  out  16  mismatching beats, saturates at 16'hFFFF.
- err_flag  out  1  sticky, set on the first mismatch.
- first_err_exp  out  DATA_WIDTH  expected value at the first mismatch.
- first_err_act  out  DATA_WIDTH  received value at the first mismatch.
- done  out  1  NUM_BEATS reached.
- pass  out  1  done and err_count == 0.

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE; axis_tready = 0; all counts, flags and first_err_* = 0; expected = START_VAL; lfsr = LFSR_SEED.
- Accept: a beat is accepted on a posedge where axis_tvalid && axis_tready. axis_tdata is never sampled otherwise.
- States:
  - IDLE: tready = 0. If chk_en = 1, go to RUN next cycle.
  - RUN: tready is registered, so the value for the next cycle is computed each cycle.
    - READY_MODE 0: tready = 1.
    - READY_MODE 1: tready = (lfsr[1:0] != 2'b00).
    - The LFSR is 16-bit Fibonacci, taps 16/14/13/11, shifts every RUN cycle and holds in other states.
  - DONE: tready = 0, done = 1, counters frozen. Exit only by clr or reset.
- First tready: it rises the cycle after entering RUN, so the earliest accept is 2 cycles after chk_en is sampled.
- Check on accept:
  - Match if axis_tdata == expected. Otherwise err_count++ (saturating), and if err_flag = 0, latch first_err_exp/first_err_act and set err_flag.
  - Next expected = axis_tdata + 1 in both cases. This resync means one dropped or duplicated beat yields exactly one error, not a cascade.
  - Arithmetic is mod 2^DATA_WIDTH: all-ones followed by 0 is a match.
- rx_count increments on every accept.
- Done: with NUM_BEATS != 0, the accept that makes rx_count == NUM_BEATS moves the state to DONE and drives tready = 0 on the next cycle. No beat beyond NUM_BEATS is ever accepted.
- pass is combinational: done && (err_count == 0).
- clr:
  - Takes priority over accept in the same cycle; that beat is not counted.
  - Clears counts, flags and first_err_*; sets expected = START_VAL; reloads lfsr = LFSR_SEED; sets tready = 0; goes to IDLE.
- Holding chk_en low in RUN has no effect; it is only sampled in IDLE.
- Reset mid-stream: immediate return to reset values, with tready dropping asynchronously. The upstream generator holds tvalid/tdata per AXIS rules.
- No combinational path from any input to axis_tready.

Test Plan:
- Generator connected, READY_MODE 0, NUM_BEATS 16, chk_en pulsed -> beats 1..16 accepted, rx_count = 16, err_count = 0, done = 1, pass = 1, tready = 0 thereafter.
- READY_MODE 1, NUM_BEATS 200 -> tready toggles, no beat lost, rx_count = 200, pass = 1; the tready pattern repeats identically after clr.
- Bench stream 1,2,3,5,6 -> err_count = 1, err_flag = 1, first_err_exp = 4, first_err_act = 5, next beat 6 is not counted as an error.
- DATA_WIDTH 8, START_VAL 8'hFE, stream FE,FF,00,01 -> err_count = 0 (wrap is legal).
- rst driven low for one cycle mid-stream after 10 beats -> outputs return to reset values asynchronously; after re-enable, first beat 1 is checked cleanly.
- clr asserted in the same cycle as a valid accept -> rx_count = 0, state IDLE, tready = 0 next cycle.
